// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-channel arbiter.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } uart_arb_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: the first requester strictly after i_ptr
// (wrapping) wins, so the pointer's own index is checked last.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from farthest to nearest so the nearest valid index overwrites the rest
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_onehot                          = '0;
                o_onehot[(int'(i_ptr) + k) % N]   = 1'b1;
                o_idx                             = IDX_W'((int'(i_ptr) + k) % N);
                o_any                             = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit byte channel between NUM_REQ
// requesters. A grant stays locked for a whole message (last flag or burst cap).
// Optional feature: define UART_ARB_TIMEOUT_EN to release an owner that stays
// idle for TIMEOUT_CYCLES consecutive cycles (pulses timeout_o).
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ARB_IDLE   | no owner; arbitrate among valid requesters, grant next cycle
//   ARB_LOCKED | owner passes bytes straight through to the UART until release
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int MAX_BURST      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [UART_BYTE_W-1:0]         tx_data_o,
    output logic                           tx_valid_o,
    input  logic                           tx_ready_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           busy_o,
    output logic                           timeout_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    uart_arb_state_e    r_state;
    uart_arb_state_e    w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic [CNT_W-1:0]   r_byte_cnt;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_xfer;
    logic               w_cap_hit;
    logic               w_release;
    logic               w_timeout;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_rr_pick (
        .i_req    (req_valid_i),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // The byte being accepted now is the MAX_BURST-th of this grant
    assign w_cap_hit = (MAX_BURST != 0) && (r_byte_cnt == CNT_W'(MAX_BURST - 1));

`ifdef UART_ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] r_idle_cnt;

    // Fires during the TIMEOUT_CYCLES-th consecutive cycle the owner has no byte
    assign w_timeout = (r_state == ARB_LOCKED) && !req_valid_i[r_owner] &&
                       (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive owner-idle cycles while locked; any valid byte clears it
    always_ff @(posedge clk_i) begin
        if (rst_i || r_state != ARB_LOCKED || req_valid_i[r_owner] || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign grant_o   = r_grant;
    assign busy_o    = (r_state == ARB_LOCKED);
    assign timeout_o = w_timeout;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus combinational pass-through of the owner's byte channel
    always_comb begin
        w_state_nxt = r_state;
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;
        w_xfer      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                tx_valid_o           = req_valid_i[r_owner];
                req_ready_o[r_owner] = tx_ready_i;
                if (req_valid_i[r_owner]) begin
                    tx_data_o = req_data_i[r_owner*UART_BYTE_W +: UART_BYTE_W];
                end
                w_xfer    = req_valid_i[r_owner] && tx_ready_i;
                w_release = (w_xfer && (req_last_i[r_owner] || w_cap_hit)) || w_timeout;
                if (w_release) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Grant capture, pointer rotation on release, and per-grant byte counting
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= PTR_W'(NUM_REQ - 1);
            r_owner    <= '0;
            r_grant    <= '0;
            r_byte_cnt <= '0;
        end else if (r_state == ARB_IDLE && w_pick_any) begin
            r_owner    <= w_pick_idx;
            r_grant    <= w_pick_onehot;
            r_byte_cnt <= '0;
        end else if (w_release) begin
            r_rr_ptr   <= r_owner;
            r_grant    <= '0;
            r_byte_cnt <= '0;
        end else if (w_xfer && r_byte_cnt != {CNT_W{1'b1}}) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=2, MAX_BURST=4, TIMEOUT_CYCLES=8).
// Observed vector layout: {grant[1:0], busy, timeout, tx_valid, tx_data[7:0], req_ready[1:0]}.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic [1:0]  req_valid_i = '0;
    logic [1:0]  req_last_i  = '0;
    logic [7:0]  d0          = '0;
    logic [7:0]  d1          = '0;
    logic        tx_ready_i  = 1'b1;
    logic [15:0] req_data_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  grant_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        busy_o;
    logic        timeout_o;
    logic [14:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    assign req_data_i = {d1, d0};
    assign obs = {grant_o, busy_o, timeout_o, tx_valid_o, tx_data_o, req_ready_o};

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(
        .NUM_REQ        (2),
        .MAX_BURST      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    // Expected observation while LOCKED
    function automatic logic [14:0] lk(input logic [1:0] g, input logic tv,
                                       input logic [7:0] d, input logic [1:0] r,
                                       input logic to);
        return {g, 1'b1, to, tv, d, r};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] e;
        rst_i = 1'b1;
        step(); step(); step();
        #2;
        e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs, e); end
        rst_i = 1'b0;
    endtask

    task automatic test_single_msg();
        logic [14:0] e;
        req_valid_i = 2'b01; d0 = 8'h41; req_last_i = 2'b00;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t1_arb_cycle got=%h exp=%h", obs, e); end
        step(); #2; e = lk(2'b01, 1'b1, 8'h41, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t1_byte41 got=%h exp=%h", obs, e); end
        step(); d0 = 8'h42;
        #2; e = lk(2'b01, 1'b1, 8'h42, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t1_byte42 got=%h exp=%h", obs, e); end
        step(); d0 = 8'h43; req_last_i = 2'b01;
        #2; e = lk(2'b01, 1'b1, 8'h43, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t1_byte43 got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b00; req_last_i = 2'b00;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t1_release got=%h exp=%h", obs, e); end
    endtask

    task automatic test_round_robin();
        logic [14:0] e;
        rst_i = 1'b1; req_valid_i = 2'b11; d0 = 8'hA0; d1 = 8'hB0; req_last_i = 2'b00;
        step(); step(); rst_i = 1'b0;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_idle got=%h exp=%h", obs, e); end
        step(); #2; e = lk(2'b01, 1'b1, 8'hA0, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_r0_b0 got=%h exp=%h", obs, e); end
        step(); d0 = 8'hA1; req_last_i = 2'b01;
        #2; e = lk(2'b01, 1'b1, 8'hA1, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_r0_b1 got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b10; req_last_i = 2'b00;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_gap got=%h exp=%h", obs, e); end
        step(); #2; e = lk(2'b10, 1'b1, 8'hB0, 2'b10, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_r1_b0 got=%h exp=%h", obs, e); end
        step(); d1 = 8'hB1; req_last_i = 2'b10;
        #2; e = lk(2'b10, 1'b1, 8'hB1, 2'b10, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_r1_b1 got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b11; d0 = 8'hC0; d1 = 8'hD0; req_last_i = 2'b11;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_gap2 got=%h exp=%h", obs, e); end
        step(); #2; e = lk(2'b01, 1'b1, 8'hC0, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_rotate_r0 got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b10;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_gap3 got=%h exp=%h", obs, e); end
        step(); #2; e = lk(2'b10, 1'b1, 8'hD0, 2'b10, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_rotate_r1 got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b00; req_last_i = 2'b00;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t2_end got=%h exp=%h", obs, e); end
    endtask

    task automatic test_burst_cap();
        logic [14:0] e;
        req_valid_i = 2'b10; d1 = 8'h60; req_last_i = 2'b00;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t3_idle got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b11; d0 = 8'h70; req_last_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #2; e = lk(2'b10, 1'b1, 8'(8'h60 + i), 2'b10, 1'b0);
            n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t3_burst_byte%0d got=%h exp=%h", i, obs, e); end
            step(); d1 = 8'(8'h61 + i);
        end
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t3_cap_release got=%h exp=%h", obs, e); end
        step(); #2; e = lk(2'b01, 1'b1, 8'h70, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t3_r0_next got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b00; req_last_i = 2'b00;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t3_end got=%h exp=%h", obs, e); end
    endtask

    task automatic test_backpressure();
        logic [14:0] e;
        req_valid_i = 2'b01; d0 = 8'h51; req_last_i = 2'b00;
        step(); #2; e = lk(2'b01, 1'b1, 8'h51, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t4_first got=%h exp=%h", obs, e); end
        step(); d0 = 8'h52; tx_ready_i = 1'b0; req_valid_i = 2'b11; d1 = 8'h99; req_last_i = 2'b10;
        for (int i = 0; i < 10; i++) begin
            #2; e = lk(2'b01, 1'b1, 8'h52, 2'b00, 1'b0);
            n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t4_stall%0d got=%h exp=%h", i, obs, e); end
            step();
        end
        tx_ready_i = 1'b1; req_last_i = 2'b11;
        #2; e = lk(2'b01, 1'b1, 8'h52, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t4_resume got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b10;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t4_release got=%h exp=%h", obs, e); end
        step(); #2; e = lk(2'b10, 1'b1, 8'h99, 2'b10, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t4_r1_next got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b00; req_last_i = 2'b00;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t4_end got=%h exp=%h", obs, e); end
    endtask

    task automatic test_owner_idle();
        logic [14:0] e;
        req_valid_i = 2'b01; d0 = 8'h33; req_last_i = 2'b00;
        step(); #2; e = lk(2'b01, 1'b1, 8'h33, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t5_first got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b10; d1 = 8'h44; req_last_i = 2'b10;
`ifdef UART_ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            #2; e = lk(2'b01, 1'b0, 8'h00, 2'b01, (k == 8));
            n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t5_idle%0d got=%h exp=%h", k, obs, e); end
            step();
        end
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t5_timeout_idle got=%h exp=%h", obs, e); end
`else
        for (int k = 1; k <= 100; k++) begin
            #2; e = lk(2'b01, 1'b0, 8'h00, 2'b01, 1'b0);
            n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t5_hold%0d got=%h exp=%h", k, obs, e); end
            step();
        end
        req_valid_i = 2'b11; d0 = 8'h34; req_last_i = 2'b11;
        #2; e = lk(2'b01, 1'b1, 8'h34, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t5_resume got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b10;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t5_release got=%h exp=%h", obs, e); end
`endif
        step(); #2; e = lk(2'b10, 1'b1, 8'h44, 2'b10, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t5_other_granted got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b00; req_last_i = 2'b00;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t5_end got=%h exp=%h", obs, e); end
    endtask

    task automatic test_reset_mid_msg();
        logic [14:0] e;
        req_valid_i = 2'b01; d0 = 8'h10; req_last_i = 2'b01;
        step(); #2; e = lk(2'b01, 1'b1, 8'h10, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t6_r0 got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b10; d1 = 8'h55; req_last_i = 2'b00;
        step(); #2; e = lk(2'b10, 1'b1, 8'h55, 2'b10, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t6_r1 got=%h exp=%h", obs, e); end
        step(); rst_i = 1'b1; req_valid_i = 2'b11; d0 = 8'h66; req_last_i = 2'b01;
        #2; e = lk(2'b10, 1'b1, 8'h55, 2'b10, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t6_pre_reset got=%h exp=%h", obs, e); end
        step(); #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t6_reset_outputs got=%h exp=%h", obs, e); end
        rst_i = 1'b0;
        step(); #2; e = lk(2'b01, 1'b1, 8'h66, 2'b01, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t6_r0_wins got=%h exp=%h", obs, e); end
        step(); req_valid_i = 2'b00; req_last_i = 2'b00;
        #2; e = '0;
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL t6_end got=%h exp=%h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_owner_idle();
        test_reset_mid_msg();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
